audio_step_sequencer: RTL and testbench
=======================================

Name: audio_step_sequencer

Overview:
Controller that sequences a 5-bit audio step counter for game sound playback. Converts a start/stop/pause command interface into tempo-paced counter enables. Presents the current step index to the tone/lookup stage and gates its output with note_en. Supports one-shot and looping playback, with a start acknowledge and a completion pulse for the game FSM.

Parameters:
TEMPO_DIV, 3125000, clock cycles per step (32 steps/s at 100 MHz); minimum 2
LAST_STEP, 31, final step index before wrap or finish; range 0..31

Ports:
clk  input  1  system clock, rising edge
clr_n  input  1  asynchronous active-low reset
start  input  1  play request, sampled each cycle
stop  input  1  abort playback, sampled each cycle
pause  input  1  level: hold playback while high
loop_en  input  1  latched at accepted start; 1 = loop, 0 = one-shot
start_ack  output  1  one-cycle pulse: start accepted
step  output  5  current step index
step_tick  output  1  one-cycle pulse on each step advance
note_en  output  1  tone output enable, high only in PLAY
busy  output  1  high in PLAY or PAUSE
done  output  1  one-cycle pulse: one-shot sequence completed

Behaviour:
- Clock is clk; reset is asynchronous, active-low (clr_n). All outputs are registered.
- Reset (clr_n low, effective immediately, including mid-play): state IDLE; step=0, prescaler=0, latched loop=0; start_ack, step_tick, note_en, busy and done all 0.
- States: IDLE, PLAY, PAUSE, DONE.
- IDLE: if start=1 and stop=0:
  - enter PLAY; step=0, prescaler=0; latch loop_en.
  - start_ack=1 for exactly that next cycle.
  - If stop=1 in the same cycle, start is ignored.
- PLAY: note_en=1, busy=1.
  - Priority: stop > pause > tick.
  - stop=1: next state IDLE; step=0, prescaler=0; no done pulse.
  - pause=1 (stop=0): next state PAUSE; prescaler and step hold; no tick that cycle, even at terminal count.
  - Otherwise the prescaler increments. At prescaler==TEMPO_DIV-1:
    - prescaler returns to 0; step_tick pulses for 1 cycle.
    - If step<LAST_STEP: step+1.
    - If step==LAST_STEP and looping: step=0, stay in PLAY.
    - If step==LAST_STEP and one-shot: step=0, go to DONE.
- PAUSE: busy=1, note_en=0; counters frozen.
  - stop=1 goes to IDLE (cleared as above).
  - pause=0 returns to PLAY with the counters resuming from their held values.
- DONE: lasts exactly 1 cycle; done=1, busy=0, note_en=0; then IDLE.
  - start in DONE is accepted exactly as in IDLE.
- start while busy: ignored, no start_ack.
- Timing:
  - First step_tick occurs TEMPO_DIV cycles after entering PLAY.
  - One-shot duration from PLAY entry to DONE is (LAST_STEP+1)*TEMPO_DIV cycles, excluding paused cycles.
- Width rules:
  - Prescaler width is clog2(TEMPO_DIV).
  - step is 5 bits and never exceeds LAST_STEP.
  - No wrap occurs outside the defined LAST_STEP transition.

Decomposition:
- Package audio_seq_pkg:
  - state enum: IDLE=2'b00, PLAY=2'b01, PAUSE=2'b10, DONE=2'b11
  - STEP_W=5
- Sub-module step_counter_5: 5-bit counter with inputs en, sync_clr and async clr_n.
  - The sequencer drives en from the tick condition.
  - It drives sync_clr on start, stop and the final-step transition.
- Prescaler and FSM live in the top module.

Test Plan:
- Reset: hold clr_n=0 with random inputs -> all outputs 0, step=0; release, stay idle with no start -> outputs remain 0.
- One-shot, TEMPO_DIV=4: pulse start, loop_en=0 ->
  - start_ack the next cycle, busy=1.
  - step_tick every 4 cycles; step goes 0..31.
  - done pulses once 128 cycles after PLAY entry; then busy=0, step=0.
- Loop, TEMPO_DIV=4: start with loop_en=1 -> after the step 31 tick, step=0, no done, busy stays 1 over 300 cycles.
- Pause at step 5 for 10 cycles, asserted at prescaler terminal count ->
  - step holds 5, note_en=0, busy=1, no step_tick.
  - After release, first tick in 1 cycle; step=6.
- Stop at step 9 -> next cycle busy=0, step=0, no done.
- Start handling:
  - start with stop in the same IDLE cycle -> no start_ack.
  - start while busy -> ignored.
- Async reset: drop clr_n between clock edges at step 12 -> outputs 0 before the next edge; after release the block idles until a new start.

Source files
------------

// File: rtl/audio_seq_pkg.sv
// Shared types for the audio step sequencer.
// FSM state encoding and step width.
package audio_seq_pkg;

  localparam int STEP_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/step_counter_5.sv
// Step index counter with synchronous clear and enable.
// Clear has priority over the increment.
module step_counter_5
  import audio_seq_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  input  logic              sync_clr,
  output logic [STEP_W-1:0] cnt
);

  logic [STEP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/audio_step_sequencer.sv
// Tempo-paced step sequencer for game sound playback.
// Prescaler and FSM here; the step index lives in step_counter_5.
module audio_step_sequencer
  import audio_seq_pkg::*;
#(
  parameter int unsigned TEMPO_DIV = 3125000,
  parameter int unsigned LAST_STEP = 31
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic              start_ack,
  output logic [STEP_W-1:0] step,
  output logic              step_tick,
  output logic              note_en,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(TEMPO_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TEMPO_DIV - 1);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(LAST_STEP);

  seq_state_e    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          loop_q, loop_d;
  logic          ack_q, tick_q, note_q, busy_q, done_q;

  logic accept, active, tc, tick, last;
  logic cnt_en, cnt_clr;

  assign active = (state_q == PLAY) || (state_q == PAUSE);
  assign accept = start && !stop && !active;
  assign tc     = (pre_q == PMAX);
  assign tick   = (state_q == PLAY) && !stop && !pause && tc;
  assign last   = (step == LAST);

  assign cnt_en  = tick && !last;
  assign cnt_clr = accept || (active && stop) || (tick && last);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    loop_d  = loop_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = PLAY;
          pre_d   = '0;
          loop_d  = loop_en;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          pre_d   = '0;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (tc) begin
          pre_d = '0;
          if (last && !loop_q)
            state_d = DONE;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          pre_d   = '0;
        end else if (!pause) begin
          state_d = PLAY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      loop_q  <= 1'b0;
      ack_q   <= 1'b0;
      tick_q  <= 1'b0;
      note_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      loop_q  <= loop_d;
      ack_q   <= accept;
      tick_q  <= tick;
      note_q  <= (state_d == PLAY);
      busy_q  <= (state_d == PLAY) || (state_d == PAUSE);
      done_q  <= (state_d == DONE);
    end
  end

  step_counter_5 u_cnt (
    .clk      (clk),
    .clr_n    (clr_n),
    .en       (cnt_en),
    .sync_clr (cnt_clr),
    .cnt      (step)
  );

  assign start_ack = ack_q;
  assign step_tick = tick_q;
  assign note_en   = note_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_audio_step_sequencer.sv
// Bench for audio_step_sequencer: directed table, corner sequences
// and random traffic against an elapsed-time playback model.
module tb_audio_step_sequencer;

  localparam int TD    = 4;
  localparam int LS    = 31;
  localparam int TOTAL = (LS + 1) * TD;

  logic       clk;
  logic       clr_n;
  logic       start, stop, pause, loop_en;
  logic       start_ack, step_tick, note_en, busy, done;
  logic [4:0] step;

  audio_step_sequencer #(
    .TEMPO_DIV (TD),
    .LAST_STEP (LS)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .start_ack (start_ack),
    .step      (step),
    .step_tick (step_tick),
    .note_en   (note_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // playback model: elapsed un-paused play cycles since start
  bit m_act, m_pz, m_loop;
  int m_el;
  bit e_ack, e_tick, e_done;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_act = 0; m_pz = 0; m_loop = 0; m_el = 0;
    e_ack = 0; e_tick = 0; e_done = 0;
  endtask

  task automatic m_step(input bit s, input bit p, input bit a, input bit l);
    e_ack = 0; e_tick = 0; e_done = 0;
    if (!m_act) begin
      if (s && !p) begin
        m_act = 1; m_pz = 0; m_loop = l; m_el = 0; e_ack = 1;
      end
    end else if (p) begin
      m_act = 0; m_pz = 0; m_el = 0;
    end else if (m_pz) begin
      if (!a) m_pz = 0;
    end else if (a) begin
      m_pz = 1;
    end else begin
      m_el++;
      if (m_el % TD == 0) e_tick = 1;
      if (m_el == TOTAL) begin
        m_el = 0;
        if (!m_loop) begin
          m_act = 0; e_done = 1;
        end
      end
    end
  endtask

  task automatic chk_model();
    chk("ack",  16'(start_ack), 16'(e_ack));
    chk("tick", 16'(step_tick), 16'(e_tick));
    chk("done", 16'(done),      16'(e_done));
    chk("busy", 16'(busy),      16'(m_act));
    chk("note", 16'(note_en),   16'(m_act && !m_pz));
    chk("step", 16'(step),      16'(m_el / TD));
  endtask

  task automatic drive(input bit s, input bit p, input bit a, input bit l);
    start = s; stop = p; pause = a; loop_en = l;
    @(posedge clk);
    #1;
    m_step(s, p, a, l);
  endtask

  task automatic cyc(input bit s, input bit p, input bit a, input bit l);
    drive(s, p, a, l);
    chk_model();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_out"}, 16'({start_ack, step_tick, note_en, busy, done}), 16'd0);
    chk({nm, "_step"}, 16'(step), 16'd0);
  endtask

  typedef struct {
    bit s, p, a, l;
    bit ack, bsy, note, tick, dn;
    logic [4:0] stp;
  } vec_t;

  vec_t tv[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt_t, cnt_d;
    bit seen, pz;
    tv[0] = '{1,1,0,0, 0,0,0,0,0, 5'd0};
    tv[1] = '{1,0,0,0, 1,1,1,0,0, 5'd0};
    tv[2] = '{1,0,0,0, 0,1,1,0,0, 5'd0};
    tv[3] = '{0,0,0,0, 0,1,1,0,0, 5'd0};
    tv[4] = '{0,0,0,0, 0,1,1,0,0, 5'd0};
    tv[5] = '{0,0,0,0, 0,1,1,1,0, 5'd1};
    tv[6] = '{0,0,1,0, 0,1,0,0,0, 5'd1};
    tv[7] = '{0,1,0,0, 0,0,0,0,0, 5'd0};

    clr_n = 0;
    start = 0; stop = 0; pause = 0; loop_en = 0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); stop = 1'($urandom);
      pause = 1'($urandom); loop_en = 1'($urandom);
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    @(negedge clk);
    clr_n = 1;
    start = 0; stop = 0; pause = 0; loop_en = 0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

    foreach (tv[i]) begin
      drive(tv[i].s, tv[i].p, tv[i].a, tv[i].l);
      chk("tv_ack",  16'(start_ack), 16'(tv[i].ack));
      chk("tv_busy", 16'(busy),      16'(tv[i].bsy));
      chk("tv_note", 16'(note_en),   16'(tv[i].note));
      chk("tv_tick", 16'(step_tick), 16'(tv[i].tick));
      chk("tv_done", 16'(done),      16'(tv[i].dn));
      chk("tv_step", 16'(step),      16'(tv[i].stp));
    end

    // one-shot: done exactly 128 cycles after entering PLAY
    cyc(1, 0, 0, 0);
    n = 0; seen = 0; cnt_t = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc(0, 0, 0, 0);
      n++;
      if (step_tick) cnt_t++;
      if (done) seen = 1;
    end
    chk("oneshot_done_lat", 16'(n), 16'(TOTAL));
    chk("oneshot_ticks", 16'(cnt_t), 16'(LS + 1));
    cyc(0, 0, 0, 0);
    chk("oneshot_after_busy", 16'(busy), 16'd0);

    // looping: no done, busy throughout
    cyc(1, 0, 0, 1);
    cnt_d = 0; cnt_t = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(0, 0, 0, 0);
      if (done) cnt_d++;
      if (!busy) cnt_d++;
      if (step_tick) cnt_t++;
    end
    chk("loop_no_done", 16'(cnt_d), 16'd0);
    chk("loop_ticks", 16'(cnt_t), 16'(300 / TD));
    cyc(0, 1, 0, 0);

    // pause at step 5 on terminal prescaler count
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5 * TD + TD - 1; i++) cyc(0, 0, 0, 0);
    chk("pre_pause_step", 16'(step), 16'd5);
    cnt_t = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0);
      if (step_tick) cnt_t++;
    end
    chk("pause_ticks", 16'(cnt_t), 16'd0);
    chk("pause_step", 16'(step), 16'd5);
    chk("pause_note", 16'(note_en), 16'd0);
    chk("pause_busy", 16'(busy), 16'd1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("resume_tick", 16'(step_tick), 16'd1);
    chk("resume_step", 16'(step), 16'd6);

    // start while busy, then stop at step 9
    cyc(1, 0, 0, 1);
    chk("busy_start_ack", 16'(start_ack), 16'd0);
    for (int i = 0; i < 3 * TD - 1; i++) cyc(0, 0, 0, 0);
    chk("pre_stop_step", 16'(step), 16'd9);
    cyc(0, 1, 0, 0);
    chk("stop_busy", 16'(busy), 16'd0);
    chk("stop_step", 16'(step), 16'd0);
    chk("stop_done", 16'(done), 16'd0);

    // asynchronous reset between edges at step 12
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 12 * TD; i++) cyc(0, 0, 0, 0);
    chk("pre_arst_step", 16'(step), 16'd12);
    @(negedge clk);
    clr_n = 0;
    #1;
    chk_zero("arst");
    m_reset();
    @(negedge clk);
    clr_n = 1;
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);

    // random traffic
    pz = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) pz = !pz;
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0,
          pz, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
